// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised loadable up/down counter with MIN/MAX
// bounds, wrap or saturate at the bounds, a registered terminal-count pulse
// and sticky overflow/underflow flags.
// Optional feature macro: UDCNT_PRESCALE_EN adds a prescale input and an
// enable prescaler so the counter steps once every (prescale+1) enabled cycles.
module param_updown_counter #(
    parameter int              WIDTH      = 8,
    parameter longint unsigned MIN_VAL    = 0,
    parameter longint unsigned MAX_VAL    = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE   = 1'b0,
    parameter int              PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      din,
    input  logic                  up_down,
    input  logic                  clr_flags,
`ifdef UDCNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  unf,
    output logic                  at_max,
    output logic                  at_min
);

    // Reject bound/width combinations the counter cannot represent.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_updown_counter: WIDTH must be 2..32");
    end
    if (!(MIN_VAL < MAX_VAL) || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_bounds
        $fatal(1, "param_updown_counter: require MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (PRESCALE_W < 1) begin : g_bad_prescale
        $fatal(1, "param_updown_counter: PRESCALE_W must be at least 1");
    end

    localparam logic [WIDTH-1:0] MIN_V = MIN_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

    logic             step;
    logic             hit_max;
    logic             hit_min;
    logic [WIDTH-1:0] din_clamped;

    // Boundary detection is a plain equality compare on the registered count.
    assign at_max  = (count == MAX_V);
    assign at_min  = (count == MIN_V);
    assign hit_max = step &&  up_down && at_max;
    assign hit_min = step && !up_down && at_min;

    // Clamp load data into [MIN_V, MAX_V]; inclusive compares avoid constant-compare corner cases.
    always_comb begin
        din_clamped = din;
        if (din >= MAX_V)
            din_clamped = MAX_V;
        else if (din <= MIN_V)
            din_clamped = MIN_V;
    end

`ifdef UDCNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] ps_cnt;
    logic [PRESCALE_W-1:0] ps_lim;
    logic [PRESCALE_W-1:0] ps_target;

    // A freshly cleared prescaler uses the live prescale value; mid-period it
    // uses the value captured at period start, so changes apply after a clear.
    assign ps_target = (ps_cnt == '0) ? prescale : ps_lim;
    assign step      = en && !load && (ps_cnt == ps_target);

    // Prescaler: counts enabled cycles, clears on load and after every step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
            ps_lim <= '0;
        end else if (load) begin
            ps_cnt <= '0;
        end else if (en) begin
            if (ps_cnt == ps_target) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
                if (ps_cnt == '0)
                    ps_lim <= prescale;
            end
        end
    end
`else
    assign step = en && !load;
`endif

    // Count register with load priority over stepping, plus the tc pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= MIN_V;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= din_clamped;
            end else if (step) begin
                if (up_down) begin
                    if (at_max) begin
                        count <= SATURATE ? MAX_V : MIN_V;
                        tc    <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    if (at_min) begin
                        count <= SATURATE ? MIN_V : MAX_V;
                        tc    <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    end

    // Sticky flags: a boundary step sets, clr_flags clears, set wins a tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= hit_max || (ovf && !clr_flags);
            unf <= hit_min || (unf && !clr_flags);
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: one wrapping and one saturating
// instance (WIDTH=4, MIN=2, MAX=12) driven by the same stimulus.
module tb_param_updown_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] din;
    logic       up_down;
    logic       clr_flags;
`ifdef UDCNT_PRESCALE_EN
    logic [3:0] prescale;
`endif

    logic [3:0] w_count, s_count;
    logic       w_tc, w_ovf, w_unf, w_at_max, w_at_min;
    logic       s_tc, s_ovf, s_unf, s_at_max, s_at_min;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    param_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .SATURATE(1'b0), .PRESCALE_W(4)) u_wrap (
        .clock(clock), .reset(reset), .en(en), .load(load), .din(din),
        .up_down(up_down), .clr_flags(clr_flags),
`ifdef UDCNT_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(w_count), .tc(w_tc), .ovf(w_ovf), .unf(w_unf),
        .at_max(w_at_max), .at_min(w_at_min)
    );

    param_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .SATURATE(1'b1), .PRESCALE_W(4)) u_sat (
        .clock(clock), .reset(reset), .en(en), .load(load), .din(din),
        .up_down(up_down), .clr_flags(clr_flags),
`ifdef UDCNT_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(s_count), .tc(s_tc), .ovf(s_ovf), .unf(s_unf),
        .at_max(s_at_max), .at_min(s_at_min)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check all outputs of the wrap instance.
    task automatic chk_w(input string tag, input int cnt, input bit t, input bit o, input bit u);
        chk({tag, " w.count"}, 32'(w_count), 32'(cnt));
        chk({tag, " w.tc"},    32'(w_tc),    32'(t));
        chk({tag, " w.ovf"},   32'(w_ovf),   32'(o));
        chk({tag, " w.unf"},   32'(w_unf),   32'(u));
    endtask

    // Check all outputs of the saturate instance.
    task automatic chk_s(input string tag, input int cnt, input bit t, input bit o, input bit u);
        chk({tag, " s.count"}, 32'(s_count), 32'(cnt));
        chk({tag, " s.tc"},    32'(s_tc),    32'(t));
        chk({tag, " s.ovf"},   32'(s_ovf),   32'(o));
        chk({tag, " s.unf"},   32'(s_unf),   32'(u));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; din = 4'd0; up_down = 1'b1; clr_flags = 1'b0;
`ifdef UDCNT_PRESCALE_EN
        prescale = 4'd0;
`endif
        #1;
        chk_w("reset", 2, 0, 0, 0);
        chk_s("reset", 2, 0, 0, 0);
        chk("reset w.at_min", 32'(w_at_min), 32'd1);
        chk("reset w.at_max", 32'(w_at_max), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_w("idle", 2, 0, 0, 0);

        // Reset mid-count: asynchronous, visible before the next edge.
        load = 1'b1; din = 4'd7;
        tick();
        chk_w("load7", 7, 0, 0, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick();
        chk_w("step8", 8, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_w("async_rst", 2, 0, 0, 0);
        chk_s("async_rst", 2, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_w("post_rst_step", 3, 0, 0, 0);
        en = 1'b0;

        // Wrap / saturate at MAX going up.
        load = 1'b1; din = 4'd11;
        tick();
        chk_w("load11", 11, 0, 0, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick();
        chk_w("up12", 12, 0, 0, 0);
        chk("up12 w.at_max", 32'(w_at_max), 32'd1);
        tick();
        chk_w("wrap_up", 2, 1, 1, 0);
        chk_s("sat_up", 12, 1, 1, 0);
        en = 1'b0; up_down = 1'b0;
        tick();
        chk_w("hold_after_wrap", 2, 0, 1, 0);
        chk_s("hold_after_sat", 12, 0, 1, 0);

        // Saturate / wrap at MIN going down.
        load = 1'b1; din = 4'd3;
        tick();
        chk_w("load3", 3, 0, 1, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        tick();
        chk_w("down2", 2, 0, 1, 0);
        chk_s("down2", 2, 0, 1, 0);
        tick();
        chk_w("wrap_down", 12, 1, 1, 1);
        chk_s("sat_down1", 2, 1, 1, 1);
        tick();
        chk_w("down11", 11, 0, 1, 1);
        chk_s("sat_down2", 2, 1, 1, 1);
        chk("sat_down2 s.at_min", 32'(s_at_min), 32'd1);

        // Load clamping and load-over-enable priority.
        load = 1'b1; din = 4'd15; up_down = 1'b1;
        tick();
        chk_w("clamp_hi", 12, 0, 1, 1);
        chk_s("clamp_hi", 12, 0, 1, 1);
        din = 4'd0;
        tick();
        chk_w("clamp_lo", 2, 0, 1, 1);
        chk_s("clamp_lo", 2, 0, 1, 1);

        // Flag clear alone, then clear colliding with a boundary step.
        load = 1'b0; en = 1'b0; clr_flags = 1'b1;
        tick();
        chk_w("clr_alone", 2, 0, 0, 0);
        chk_s("clr_alone", 2, 0, 0, 0);
        clr_flags = 1'b0; load = 1'b1; din = 4'd12;
        tick();
        chk_w("load12", 12, 0, 0, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b1; clr_flags = 1'b1;
        tick();
        chk_w("clr_vs_set", 2, 1, 1, 0);
        chk_s("clr_vs_set", 12, 1, 1, 0);
        en = 1'b0; clr_flags = 1'b0; up_down = 1'b0;
        tick();
        chk_w("en0_hold", 2, 0, 1, 0);
        chk_s("en0_hold", 12, 0, 1, 0);
        tick();
        chk_w("en0_hold2", 2, 0, 1, 0);

`ifdef UDCNT_PRESCALE_EN
        // Prescale=2: one step per three enabled cycles; load restarts the spacing.
        prescale = 4'd2;
        load = 1'b1; din = 4'd4;
        tick();
        chk_w("ps_load4", 4, 0, 1, 0);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick(); chk("ps c1", 32'(w_count), 32'd4);
        tick(); chk("ps c2", 32'(w_count), 32'd4);
        tick(); chk("ps c3", 32'(w_count), 32'd5);
        tick(); chk("ps c4", 32'(w_count), 32'd5);
        tick(); chk("ps c5", 32'(w_count), 32'd5);
        tick(); chk("ps c6", 32'(w_count), 32'd6);
        tick(); tick();
        chk("ps c8", 32'(w_count), 32'd6);
        load = 1'b1; din = 4'd4;
        tick();
        chk("ps reload", 32'(w_count), 32'd4);
        load = 1'b0;
        tick(); chk("ps r1", 32'(s_count), 32'd4);
        tick(); chk("ps r2", 32'(s_count), 32'd4);
        tick(); chk("ps r3", 32'(s_count), 32'd5);
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
